// File: rtl/booth_pkg.sv
// Shared types for the sequential radix-2 Booth multiplier:
// FSM state encoding, Booth operation selector and its decode function.
package booth_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        OP_NOP = 2'd0,
        OP_ADD = 2'd1,
        OP_SUB = 2'd2
    } booth_op_t;

    // Radix-2 Booth recoding of the current multiplier bit pair {Q[0], q_1}
    function automatic booth_op_t booth_op_dec(input logic q0, input logic q_1);
        case ({q0, q_1})
            2'b01:   return OP_ADD;
            2'b10:   return OP_SUB;
            default: return OP_NOP;
        endcase
    endfunction

endpackage

// File: rtl/booth_step.sv
// One combinational Booth iteration: conditional add/subtract of M into A,
// followed by an arithmetic right shift of {A, Q, q_1}.
module booth_step
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH+1:0] i_a,
    input  logic [WIDTH:0]   i_q,
    input  logic             i_q_1,
    input  logic [WIDTH+1:0] i_m,
    output logic [WIDTH+1:0] o_a,
    output logic [WIDTH:0]   o_q,
    output logic             o_q_1
);

    logic [WIDTH+1:0] w_sum;

    always_comb begin
        w_sum = i_a;
        case (booth_op_dec(i_q[0], i_q_1))
            OP_ADD:  w_sum = i_a + i_m;
            OP_SUB:  w_sum = i_a - i_m;
            default: w_sum = i_a;
        endcase
    end

    // Shift in a copy of the sign bit; the guard bits in A keep this exact
    assign {o_a, o_q, o_q_1} = {w_sum[WIDTH+1], w_sum, i_q};

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier, signed/unsigned per operation,
// start/busy/done handshake; WIDTH+1 iterations per product.
module booth_mult_seq
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 sgn,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CNT_W = $clog2(WIDTH + 2);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH+1:0]   r_a;
    logic [WIDTH+1:0]   r_m;
    logic [WIDTH:0]     r_q;
    logic               r_q_1;
    logic [CNT_W-1:0]   r_count;
    logic               r_done;
    logic [2*WIDTH-1:0] r_product;

    logic [WIDTH+1:0]   w_a_nxt;
    logic [WIDTH:0]     w_q_nxt;
    logic               w_q_1_nxt;
    logic [WIDTH+1:0]   w_m_ext;
    logic [WIDTH:0]     w_q_ext;
    logic               w_load;
    logic               w_last;

    assign w_m_ext = sgn ? {{2{multiplicand[WIDTH-1]}}, multiplicand} : {2'b00, multiplicand};
    assign w_q_ext = sgn ? {multiplier[WIDTH-1], multiplier} : {1'b0, multiplier};

    booth_step #(.WIDTH(WIDTH)) u_step (
        .i_a   (r_a),
        .i_q   (r_q),
        .i_q_1 (r_q_1),
        .i_m   (r_m),
        .o_a   (w_a_nxt),
        .o_q   (w_q_nxt),
        .o_q_1 (w_q_1_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = CALC;
                end
            end
            CALC: begin
                if (r_count == CNT_W'(WIDTH)) begin
                    w_last      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a       <= '0;
            r_q       <= '0;
            r_q_1     <= 1'b0;
            r_m       <= '0;
            r_count   <= '0;
            r_done    <= 1'b0;
            r_product <= '0;
        end else begin
            r_done <= w_last;
            if (w_load) begin
                r_a     <= '0;
                r_q     <= w_q_ext;
                r_q_1   <= 1'b0;
                r_m     <= w_m_ext;
                r_count <= '0;
            end else if (r_state == CALC) begin
                r_a     <= w_a_nxt;
                r_q     <= w_q_nxt;
                r_q_1   <= w_q_1_nxt;
                r_count <= r_count + CNT_W'(1);
            end
            // Low 2*WIDTH bits of the post-step {A, Q}
            if (w_last) r_product <= {w_a_nxt[WIDTH-2:0], w_q_nxt};
        end
    end

    assign busy    = (r_state == CALC);
    assign done    = r_done;
    assign product = r_product;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq: directed vector table, handshake
// corner sequences and a random sweep at WIDTH=8 and WIDTH=16.
module tb_booth_mult_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start8, sgn8, busy8, done8;
    logic [7:0]  mc8, mq8;
    logic [15:0] prod8;
    logic        start16, sgn16, busy16, done16;
    logic [15:0] mc16, mq16;
    logic [31:0] prod16;

    int n_chk = 0;
    int n_err = 0;

    logic [15:0] g_p;
    int          g_lat, g_busy_n;
    logic        g_busy_at_done, g_done_after;

    typedef struct {
        bit          s;
        logic [7:0]  m;
        logic [7:0]  q;
        logic [15:0] exp;
    } vec_t;

    booth_mult_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .sgn(sgn8),
        .multiplicand(mc8), .multiplier(mq8),
        .busy(busy8), .done(done8), .product(prod8)
    );

    booth_mult_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .sgn(sgn16),
        .multiplicand(mc16), .multiplier(mq16),
        .busy(busy16), .done(done16), .product(prod16)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference product: operands read as w-bit numbers, multiplied exactly
    function automatic logic [31:0] ref_mul(input int w, input bit s,
                                            input logic [15:0] m, input logic [15:0] q);
        longint a, b, p;
        a = longint'(m);
        b = longint'(q);
        if (s && m[w-1]) a = a - (longint'(1) << w);
        if (s && q[w-1]) b = b - (longint'(1) << w);
        p = a * b;
        return 32'(p & ((longint'(1) << (2 * w)) - 1));
    endfunction

    task automatic op8(input bit s, input logic [7:0] m, input logic [7:0] q);
        @(negedge clk);
        start8 = 1'b1; sgn8 = s; mc8 = m; mq8 = q;
        @(posedge clk); #1;
        start8 = 1'b0;
        g_lat = 0; g_busy_n = 0;
        while (!done8 && g_lat < 40) begin
            if (busy8) g_busy_n++;
            @(posedge clk); #1;
            g_lat++;
        end
        g_p = prod8;
        g_busy_at_done = busy8;
        @(posedge clk); #1;
        g_done_after = done8;
    endtask

    task automatic op16(input bit s, input logic [15:0] m, input logic [15:0] q,
                        output logic [31:0] p, output int lat);
        @(negedge clk);
        start16 = 1'b1; sgn16 = s; mc16 = m; mq16 = q;
        @(posedge clk); #1;
        start16 = 1'b0;
        lat = 0;
        while (!done16 && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        p = prod16;
    endtask

    initial begin
        vec_t        vt[$];
        int          ndone, t1, t2, cyc;
        logic [15:0] p1, p2;
        logic [31:0] p16;
        int          lat16;
        bit          rs;
        logic [15:0] rm, rq;

        vt.push_back('{1'b1, 8'h07, 8'hFD, 16'hFFEB});
        vt.push_back('{1'b1, 8'h80, 8'h80, 16'h4000});
        vt.push_back('{1'b1, 8'h80, 8'h01, 16'hFF80});
        vt.push_back('{1'b0, 8'hFF, 8'hFF, 16'hFE01});
        vt.push_back('{1'b1, 8'hFF, 8'hFF, 16'h0001});
        vt.push_back('{1'b1, 8'h7F, 8'h80, 16'hC080});
        vt.push_back('{1'b0, 8'h80, 8'h80, 16'h4000});
        vt.push_back('{1'b0, 8'h01, 8'hFF, 16'h00FF});
        vt.push_back('{1'b0, 8'h00, 8'hAB, 16'h0000});
        vt.push_back('{1'b1, 8'hFD, 8'h07, 16'hFFEB});

        rst = 1'b1;
        start8 = 0; sgn8 = 0; mc8 = 0; mq8 = 0;
        start16 = 0; sgn16 = 0; mc16 = 0; mq16 = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 64'(busy8), 64'd0);
        chk("reset_done", 64'(done8), 64'd0);
        chk("reset_product", 64'(prod8), 64'd0);
        chk("reset_busy16", 64'(busy16), 64'd0);
        rst = 1'b0;

        foreach (vt[i]) begin
            op8(vt[i].s, vt[i].m, vt[i].q);
            chk($sformatf("vec%0d_product", i), 64'(g_p), 64'(vt[i].exp));
            chk($sformatf("vec%0d_latency", i), 64'(g_lat), 64'd9);
            chk($sformatf("vec%0d_busy_cycles", i), 64'(g_busy_n), 64'd9);
            chk($sformatf("vec%0d_busy_at_done", i), 64'(g_busy_at_done), 64'd0);
            chk($sformatf("vec%0d_done_one_cycle", i), 64'(g_done_after), 64'd0);
            chk($sformatf("vec%0d_product_hold", i), 64'(prod8), 64'(vt[i].exp));
        end

        // start during CALC with different operands is ignored
        @(negedge clk);
        start8 = 1'b1; sgn8 = 1'b1; mc8 = 8'h07; mq8 = 8'hFD;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        start8 = 1'b1; sgn8 = 1'b0; mc8 = 8'h09; mq8 = 8'h09;
        repeat (2) @(posedge clk);
        #1;
        start8 = 1'b0;
        ndone = 0; p1 = '0;
        for (int c = 0; c < 25; c++) begin
            if (done8) begin ndone++; p1 = prod8; end
            @(posedge clk); #1;
        end
        chk("ignore_start_done_count", 64'(ndone), 64'd1);
        chk("ignore_start_product", 64'(p1), 64'hFFEB);

        // reset in the middle of an operation
        @(negedge clk);
        start8 = 1'b1; sgn8 = 1'b0; mc8 = 8'h0C; mq8 = 8'h0B;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midreset_busy", 64'(busy8), 64'd0);
        chk("midreset_done", 64'(done8), 64'd0);
        chk("midreset_product", 64'(prod8), 64'd0);
        rst = 1'b0;
        ndone = 0;
        for (int c = 0; c < 12; c++) begin
            if (done8 || busy8) ndone++;
            @(posedge clk); #1;
        end
        chk("midreset_no_activity", 64'(ndone), 64'd0);
        op8(1'b0, 8'h03, 8'h05);
        chk("after_reset_product", 64'(g_p), 64'd15);
        chk("after_reset_latency", 64'(g_lat), 64'd9);

        // start held high: back-to-back operations
        @(negedge clk);
        start8 = 1'b1; sgn8 = 1'b0; mc8 = 8'h03; mq8 = 8'h05;
        @(posedge clk); #1;
        ndone = 0; cyc = 0; t1 = 0; t2 = 0; p1 = '0; p2 = '0;
        while (ndone < 2 && cyc < 40) begin
            if (done8) begin
                ndone++;
                if (ndone == 1) begin
                    t1 = cyc; p1 = prod8;
                    mc8 = 8'h06; mq8 = 8'h07;
                end else begin
                    t2 = cyc; p2 = prod8;
                    start8 = 1'b0;
                end
            end
            if (ndone < 2) begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        start8 = 1'b0;
        chk("b2b_done_count", 64'(ndone), 64'd2);
        chk("b2b_first_latency", 64'(t1), 64'd9);
        chk("b2b_first_product", 64'(p1), 64'd15);
        chk("b2b_second_product", 64'(p2), 64'd42);
        chk("b2b_spacing", 64'(t2 - t1), 64'd10);
        repeat (12) @(posedge clk);

        // random sweep, both widths and both modes
        for (int i = 0; i < 500; i++) begin
            rs = 1'($urandom);
            rm = 16'($urandom_range(0, 255));
            rq = 16'($urandom_range(0, 255));
            if (i % 16 == 0) rm = 16'h0080;
            if (i % 16 == 1) rm = 16'h00FF;
            op8(rs, rm[7:0], rq[7:0]);
            chk($sformatf("rand8_%0d_s%0d_%0h_x_%0h", i, rs, rm, rq), 64'(g_p),
                64'(ref_mul(8, rs, rm, rq)));
            if (g_lat != 9) chk($sformatf("rand8_%0d_latency", i), 64'(g_lat), 64'd9);
        end
        for (int i = 0; i < 500; i++) begin
            rs = 1'($urandom);
            rm = 16'($urandom);
            rq = 16'($urandom);
            if (i % 16 == 0) rm = 16'h8000;
            if (i % 16 == 1) rm = 16'hFFFF;
            op16(rs, rm, rq, p16, lat16);
            chk($sformatf("rand16_%0d_s%0d_%0h_x_%0h", i, rs, rm, rq), 64'(p16),
                64'(ref_mul(16, rs, rm, rq)));
            if (lat16 != 17) chk($sformatf("rand16_%0d_latency", i), 64'(lat16), 64'd17);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/booth_mult_seq.md
Name: booth_mult_seq

Overview:
- Parametrised sequential radix-2 Booth multiplier: owns its own FSM, iteration counter and working registers.
- Next generation of the fixed 8x8 multiplier register bank: operand width is a parameter, signed/unsigned is selectable per operation, and there is an explicit start/busy/done handshake.
- Sits between the operand capture logic and the result display/bus stage; one multiplication in flight at a time.

Parameters:
- WIDTH, 8, operand width in bits (min 2); product is 2*WIDTH bits.
- CNT_W, $clog2(WIDTH+2), iteration counter width (derived, not overridden).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request; sampled only in IDLE.
- sgn  input  1  1 = signed operands, 0 = unsigned; sampled with start.
- multiplicand  input  WIDTH  operand M, sampled with start.
- multiplier  input  WIDTH  operand Q, sampled with start.
- busy  output  1  high while the FSM is in CALC.
- done  output  1  single-cycle completion pulse.
- product  output  2*WIDTH  result; holds its value until the next completion.

Behaviour:
- Reset: synchronous, active-high, on the rising clk edge.
  - state=IDLE; A, Q, q_1, M, count, product = 0; busy=0; done=0.
  - Takes priority over everything, including mid-CALC: the operation is aborted and no done pulse is produced.
- Internal widths:
  - A: WIDTH+2 bits, signed. M: WIDTH+2 bits.
  - Q: WIDTH+1 bits. q_1: 1 bit.
  - Extension: sign-extend M and Q when sgn=1, zero-extend when sgn=0.
- FSM states are IDLE and CALC; done is a registered output, not a state.
- IDLE:
  - If start=1 at edge E0: load A=0, Q=ext(multiplier), q_1=0, M=ext(multiplicand), count=0, then go to CALC.
  - Otherwise hold all registers.
- CALC: one Booth step per clock.
  - Select on {Q[0],q_1}:
    - 01: A=A+M.
    - 10: A=A-M.
    - 00 or 11: A unchanged.
  - Then arithmetic right shift of {A,Q,q_1} by 1; count increments.
  - Exactly WIDTH+1 steps, in both modes.
- Completion: the edge performing step WIDTH+1 is edge E0+WIDTH+1.
  - product <= low 2*WIDTH bits of post-step {A,Q}.
  - done <= 1; state <= IDLE.
- Latency: done is high for exactly one cycle, starting WIDTH+1 cycles after the start-sampling edge.
- busy: high from edge E0 until edge E0+WIDTH+1. It is never high in the same cycle as done.
- start while busy=1: ignored; operands are not resampled.
- start high during the done cycle: accepted, since the FSM is in IDLE (back-to-back operation).
- start held high continuously: a new operation begins every WIDTH+2 cycles.
- Arithmetic wraps modulo 2^(WIDTH+2). The extra guard bits make the following cases exact:
  - M = -2^(WIDTH-1), signed;
  - M = 2^WIDTH-1, unsigned.
- Product interpretation: two's complement when sgn=1, unsigned when sgn=0. No overflow is possible.
- Inputs have no effect outside the start-sampling edge.

Decomposition:
- Package booth_pkg:
  - state typedef enum {IDLE, CALC};
  - Booth op typedef {OP_NOP, OP_ADD, OP_SUB};
  - function booth_op_dec(q0, q_1).
- Sub-module booth_step (combinational, parameter WIDTH):
  - inputs: A, Q, q_1, M;
  - outputs: next A, Q, q_1 after add/sub and shift.
- Top level holds the FSM, counter and all registers.

Test Plan:
- WIDTH=8, sgn=1, M=7, Q=-3, start pulse at E0 -> busy high 9 cycles; done pulses at E0+9; product=0xFFEB (-21).
- WIDTH=8, sgn=1, M=-128, Q=-128 -> product=0x4000 (16384). Also M=-128, Q=1 -> 0xFF80.
- WIDTH=8, sgn=0, M=255, Q=255 -> product=0xFE01 (65025). Same operand bits with sgn=1 -> 0x0001.
- Start during CALC with different operands -> ignored; first result unchanged; exactly one done pulse.
- rst asserted at step 4 of an operation -> next edge: busy=0, done=0, product=0. A later start completes normally.
- start held high, operands 3*5 then 6*7 -> done pulses 10 cycles apart; products 15, then 42; no gap cycle lost.
- Random sweep: WIDTH=8 and WIDTH=16, both modes, 1k vectors -> product matches reference multiply.
